// File: rtl/arb_iwrr_pkg.sv
// arb_iwrr_pkg: shared state encoding, index width and round-close helper for the IWRR arbiter
package arb_iwrr_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic round_close(input logic any_valid, input logic any_done);
    return !any_valid && any_done;
  endfunction
endpackage

// File: rtl/arb_iwrr_scheduler_granter.sv
// arb_rot_granter: rotating first-set priority granter with all-done fallback to raw requests
module arb_rot_granter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  request,
  input  logic [N-1:0]  done,
  input  logic [IW-1:0] prior_ptr,
  output logic [N-1:0]  winner
);
  logic [N-1:0] src;
  logic found;
  int k;
  always_comb begin
    src = |(request & ~done) ? (request & ~done) : request;
    winner = '0;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(prior_ptr) + i;
      if (k >= N) k = k - N;
      if (!found && src[k]) begin
        winner[k] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arb_iwrr_scheduler.sv
// arb_iwrr_scheduler: interleaved weighted round-robin arbiter with registered, sticky one-hot grant
module arb_iwrr_scheduler import arb_iwrr_pkg::*; #(
  parameter int P_REQUESTER_NUM  = 3,
  parameter int P_WEIGHT_W       = 4,
  parameter int P_INIT_PRIOR_IDX = 0,
  localparam int N  = P_REQUESTER_NUM,
  localparam int W  = P_WEIGHT_W,
  localparam int IW = idx_w(P_REQUESTER_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    request,
  input  logic [N*W-1:0]  weight,
  input  logic            grant_ready,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_idx,
  output logic            round_done
);
  state_e state_q, state_d;
  logic [N-1:0] grant_q, grant_d, done_q, done_d, winner, done_mask;
  logic [IW-1:0] grant_idx_q, grant_idx_d, ptr_q, ptr_d, win_idx;
  logic grant_valid_q, grant_valid_d, round_done_q, round_done_d, close;
  logic [N-1:0][W-1:0] cnt_q, cnt_d, wl_q, wl_d;
  logic [W:0] nxt;
  logic [W-1:0] eff;
  // Round close happens before winner selection, so the granter sees the cleared done vector
  assign close = (state_q == IDLE) && round_close(|(request & ~done_q), |done_q);
  assign done_mask = close ? '0 : done_q;
  arb_rot_granter #(.N(N), .IW(IW)) u_granter (
    .request  (request),
    .done     (done_mask),
    .prior_ptr(ptr_q),
    .winner   (winner)
  );
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) if (winner[i]) win_idx = IW'(i);
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    grant_idx_d = grant_idx_q;
    grant_valid_d = grant_valid_q;
    round_done_d = 1'b0;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    done_d = done_q;
    wl_d = wl_q;
    nxt = {1'b0, cnt_q[grant_idx_q]} + (W+1)'(1);
    eff = (wl_q[grant_idx_q] == '0) ? W'(1) : wl_q[grant_idx_q];
    if (close) begin
      cnt_d = '0;
      done_d = '0;
      wl_d = weight;
      round_done_d = 1'b1;
    end
    if (state_q == IDLE && |request) begin
      grant_d = winner;
      grant_idx_d = win_idx;
      grant_valid_d = 1'b1;
      state_d = GRANT;
    end
    if (state_q == GRANT && grant_ready) begin
      cnt_d[grant_idx_q] = nxt[W] ? cnt_q[grant_idx_q] : nxt[W-1:0];
      if (nxt >= {1'b0, eff}) done_d[grant_idx_q] = 1'b1;
      ptr_d = (grant_idx_q == IW'(N-1)) ? '0 : grant_idx_q + IW'(1);
      grant_d = '0;
      grant_valid_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      grant_idx_q <= '0;
      grant_valid_q <= 1'b0;
      round_done_q <= 1'b0;
      ptr_q <= IW'(P_INIT_PRIOR_IDX);
      cnt_q <= '0;
      done_q <= '0;
      wl_q <= weight;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      grant_idx_q <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      round_done_q <= round_done_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      wl_q <= wl_d;
    end
  end
  assign grant = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx = grant_idx_q;
  assign round_done = round_done_q;
endmodule
